quadrature_decoder: RTL



---
 rtl/quadrature_decoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes and filters an A/B encoder pair,
// then turns accepted transitions into up/down counts and error flags.
module quadrature_decoder #(
  parameter int WIDTH    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  localparam logic [3:0]       FL  = 4'(FILT_LEN);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t     state;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] pair;
  logic [1:0] cand;
  logic [1:0] acc;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [1:0] cand_nxt;
  logic       fresh;
  logic       hold;
  logic       accept;
  logic [1:0] delta;
  logic       up;
  logic       dn;
  logic       bad;

  // Position of a phase pair along the up sequence 00,10,11,01.
  function automatic logic [1:0] pos(input logic [1:0] p);
    logic [1:0] r;
    unique case (p)
      2'b00:   r = 2'd0;
      2'b10:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  assign pair = {sync_a[1], sync_b[1]};

  // Filter bookkeeping and transition classification.
  always_comb begin
    fresh    = (state == INIT) || (pair != acc);
    hold     = (pair == cand) && fresh;
    cnt_nxt  = hold ? cnt + 4'd1 : 4'd1;
    cand_nxt = hold ? cand : pair;
    accept   = (cnt_nxt == FL) && fresh;
    delta    = pos(pair) - pos(acc);
    up       = accept && (state == TRACK) && (delta == 2'd1);
    dn       = accept && (state == TRACK) && (delta == 2'd3);
    bad      = accept && (state == TRACK) && (delta == 2'd2);
  end

  // Two-flop synchronizer per phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {sync_a[0], enc_a};
      sync_b <= {sync_b[0], enc_b};
    end
  end

  // Filter state, INIT/TRACK FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cand  <= 2'b00;
      cnt   <= 4'd0;
      acc   <= 2'b00;
      count <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
      step <= (up || dn) && !clr;
      if (accept) begin
        acc   <= pair;
        state <= TRACK;
      end
      if (clr)
        count <= '0;
      else if (up)
        count <= count + ONE;
      else if (dn)
        count <= count - ONE;
      if (up)
        dir <= 1'b1;
      else if (dn)
        dir <= 1'b0;
      if (bad)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule
